// File: rtl/axi_stream_pattern_gen.sv
// AXI4-Stream pattern source: runs of packets with INCR/PRBS31/CONST/INDEX data,
// byte-granular length, programmable inter-packet gap and full back-pressure.

module axi_stream_pattern_gen_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] mode,
  input  logic [7:0] incr_base,
  input  logic [7:0] prbs_byte,
  input  logic [7:0] const_byte,
  input  logic [7:0] index_byte,
  input  logic       keep,
  output logic [7:0] data
);
  logic [7:0] pat;

  always_comb begin
    pat = '0;
    case (mode)
      2'd0:    pat = incr_base + 8'(LANE);
      2'd1:    pat = prbs_byte;
      2'd2:    pat = const_byte;
      default: pat = index_byte;
    endcase
    // bytes outside the packet on the tail beat are forced to zero
    data = keep ? pat : '0;
  end
endmodule

module axi_stream_pattern_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [LEN_WIDTH-1:0]    i_length,
  input  logic [CNT_WIDTH-1:0]    i_pkt_count,
  input  logic [7:0]              i_gap,
  input  logic [1:0]              i_mode,
  input  logic [31:0]             i_seed,
  input  logic                    i_abort,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_keep,
  output logic                    o_valid,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_WIDTH-1:0]    o_pkt_idx
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_nx;

  logic [LEN_WIDTH-1:0] cfg_len, beat_k;
  logic [CNT_WIDTH-1:0] cfg_cnt, pkt_idx;
  logic [7:0]           cfg_gap, gap_cnt;
  logic [1:0]           cfg_mode;
  logic [31:0]          cfg_seed;
  logic                 abort_pend;
  logic [30:0]          prbs_win;

  logic [LEN_WIDTH:0]   n_beats;
  logic                 last_beat, pkts_left, hs, abort_now;
  logic [BYTES-1:0]     keep_last;

  // Window holds s[n*DW .. n*DW+30]; extending it by DW bits yields this beat
  // and the window for the next one.
  function automatic logic [DATA_WIDTH+30:0] prbs_ext(input logic [30:0] w);
    logic [DATA_WIDTH+30:0] e;
    e       = '0;
    e[30:0] = w;
    for (int i = 31; i < DATA_WIDTH + 31; i++) e[i] = e[i-31] ^ e[i-28];
    return e;
  endfunction

  logic [DATA_WIDTH+30:0] prbs_bits;
  assign prbs_bits = prbs_ext(prbs_win);

  assign n_beats   = ({1'b0, cfg_len} + (LEN_WIDTH+1)'(BYTES - 1)) >> SH;
  assign last_beat = ({1'b0, beat_k} + (LEN_WIDTH+1)'(1)) == n_beats;
  assign pkts_left = ({1'b0, pkt_idx} + (CNT_WIDTH+1)'(1)) < {1'b0, cfg_cnt};
  assign hs        = o_valid & i_ready;
  assign abort_now = abort_pend | i_abort;

  always_comb begin
    keep_last = '0;
    for (int b = 0; b < BYTES; b++)
      keep_last[b] = (cfg_len[SH-1:0] == '0) || (int'(cfg_len[SH-1:0]) > b);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_start)
              state_nx = (i_length == '0 || i_pkt_count == '0) ? DONE : SEND;
      SEND: if (hs && last_beat) begin
              if (pkts_left && !abort_now) state_nx = (cfg_gap != '0) ? GAP : SEND;
              else                         state_nx = DONE;
            end
      GAP:  if (abort_now)          state_nx = DONE;
            else if (gap_cnt <= 8'd1) state_nx = SEND;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg_len    <= '0;
      cfg_cnt    <= '0;
      cfg_gap    <= '0;
      cfg_mode   <= '0;
      cfg_seed   <= '0;
      beat_k     <= '0;
      pkt_idx    <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      prbs_win   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (i_start) begin
          cfg_len    <= i_length;
          cfg_cnt    <= i_pkt_count;
          cfg_gap    <= i_gap;
          cfg_mode   <= i_mode;
          cfg_seed   <= i_seed;
          beat_k     <= '0;
          pkt_idx    <= '0;
          abort_pend <= 1'b0;
          prbs_win   <= (i_seed == '0) ? 31'd1 : i_seed[30:0];
        end
        SEND: begin
          if (i_abort) abort_pend <= 1'b1;
          if (hs) begin
            prbs_win <= prbs_bits[DATA_WIDTH+30:DATA_WIDTH];
            if (last_beat) begin
              beat_k  <= '0;
              pkt_idx <= pkt_idx + CNT_WIDTH'(1);
              gap_cnt <= cfg_gap;
            end else begin
              beat_k  <= beat_k + LEN_WIDTH'(1);
            end
          end
        end
        GAP: begin
          if (i_abort) abort_pend <= 1'b1;
          gap_cnt <= gap_cnt - 8'd1;
        end
        DONE: pkt_idx <= '0;
        default: ;
      endcase
    end
  end

  assign o_valid   = (state == SEND);
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == DONE);
  assign o_last    = o_valid & last_beat;
  assign o_pkt_idx = pkt_idx;
  assign o_keep    = o_valid ? (last_beat ? keep_last : '1) : '0;

  logic [7:0]            incr_base;
  logic [DATA_WIDTH-1:0] idx_word;
  assign incr_base = cfg_seed[7:0] + 8'(beat_k << SH);
  assign idx_word  = DATA_WIDTH'({16'(pkt_idx), 16'(beat_k)});

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    axi_stream_pattern_gen_lane #(.LANE(b)) u_lane (
      .mode       (cfg_mode),
      .incr_base  (incr_base),
      .prbs_byte  (prbs_bits[8*b +: 8]),
      .const_byte (cfg_seed[8*(b%4) +: 8]),
      .index_byte (idx_word[8*b +: 8]),
      .keep       (o_keep[b]),
      .data       (o_data[8*b +: 8])
    );
  end
endmodule

// File: tb/tb_axi_stream_pattern_gen.sv
// Bench for axi_stream_pattern_gen: byte-level reference model of each run,
// randomized back-pressure and configs, directed boundary cases.

module tb_axi_stream_pattern_gen;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int CW = 8;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_abort, i_ready;
  logic [LW-1:0] i_length;
  logic [CW-1:0] i_pkt_count;
  logic [7:0]    i_gap;
  logic [1:0]    i_mode;
  logic [31:0]   i_seed;
  logic [DW-1:0] o_data;
  logic [NB-1:0] o_keep;
  logic          o_valid, o_last, o_busy, o_done;
  logic [CW-1:0] o_pkt_idx;

  always #5 clk = ~clk;

  axi_stream_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_length(i_length),
    .i_pkt_count(i_pkt_count), .i_gap(i_gap), .i_mode(i_mode), .i_seed(i_seed),
    .i_abort(i_abort), .i_ready(i_ready), .o_data(o_data), .o_keep(o_keep),
    .o_valid(o_valid), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
    .o_pkt_idx(o_pkt_idx)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
    int            pkt;
  } beat_t;

  beat_t expq[$];
  bit    sbits[];

  // Expected beats built byte by byte from the pattern definitions.
  task automatic build(input logic [1:0] mode, input int len, input int npk,
                       input logic [31:0] seed);
    int nb, gbeat, i;
    logic [31:0] sd;
    logic [7:0]  v;
    longint      w;
    beat_t       e;
    expq.delete();
    nb = (len + NB - 1) / NB;
    if (mode == 2'd1) begin
      sd = (seed == 0) ? 32'd1 : seed;
      sbits = new[npk * nb * DW + 64];
      for (int j = 0; j < sbits.size(); j++)
        sbits[j] = (j < 31) ? sd[j] : (sbits[j-31] ^ sbits[j-28]);
    end
    gbeat = 0;
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k < nb; k++) begin
        e.data = '0; e.keep = '0; e.last = (k == nb - 1); e.pkt = p;
        for (int b = 0; b < NB; b++) begin
          i = k * NB + b;
          v = '0;
          case (mode)
            2'd0: v = 8'((seed & 32'hff) + 32'(i));
            2'd1: for (int j = 0; j < 8; j++) v[j] = sbits[gbeat * DW + b * 8 + j];
            2'd2: v = 8'(seed >> (8 * (b % 4)));
            default: begin
              w = (longint'(p) << 16) | longint'(k);
              v = 8'(w >> (8 * b));
            end
          endcase
          if (i < len) begin
            e.keep[b] = 1'b1;
            e.data[8*b +: 8] = v;
          end
        end
        expq.push_back(e);
        gbeat++;
      end
    end
  endtask

  // rmode: 0 = ready always 1, 1 = ready 1,0,1,0,0,1 repeating, 2 = random.
  // abort_hs >= 0 pulses i_abort (and a stray i_start) after that many handshakes.
  task automatic run(input string nm, input logic [1:0] mode, input int len, input int npk,
                     input int gap, input logic [31:0] seed, input int rmode, input int abort_hs);
    int eff, hs_n, pk_done, gap_seen;
    bit in_gap, prev_stall, fin, abort_sent, r;
    logic [DW-1:0] pdata;
    logic [NB-1:0] pkeep;
    logic          plast;
    beat_t         e;
    eff = (abort_hs >= 0) ? 1 : npk;
    build(mode, len, eff, seed);
    i_length = LW'(len); i_pkt_count = CW'(npk); i_gap = 8'(gap);
    i_mode = mode; i_seed = seed; i_start = 1'b1; i_abort = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    if (len == 0 || npk == 0) begin
      chk({nm, ":zero_valid"}, o_valid, 1'b0);
      chk({nm, ":zero_done"}, o_done, 1'b1);
      chk({nm, ":zero_busy"}, o_busy, 1'b1);
      @(negedge clk);
      chk({nm, ":zero_done_end"}, o_done, 1'b0);
      chk({nm, ":zero_busy_end"}, o_busy, 1'b0);
      chk({nm, ":zero_valid_end"}, o_valid, 1'b0);
      return;
    end
    chk({nm, ":start_valid"}, o_valid, 1'b1);
    chk({nm, ":start_busy"}, o_busy, 1'b1);
    hs_n = 0; pk_done = 0; gap_seen = 0;
    in_gap = 0; prev_stall = 0; fin = 0; abort_sent = 0;
    pdata = '0; pkeep = '0; plast = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = ((cyc % 6) == 0) || ((cyc % 6) == 2) || ((cyc % 6) == 5);
        default: r = 1'($urandom_range(0, 1));
      endcase
      i_ready = r;
      i_abort = (!abort_sent && abort_hs >= 0 && hs_n == abort_hs);
      i_start = i_abort;
      if (i_abort) abort_sent = 1;
      if (prev_stall) begin
        chk({nm, ":stall_valid"}, o_valid, 1'b1);
        chk({nm, ":stall_data"}, o_data, pdata);
        chk({nm, ":stall_keep"}, o_keep, pkeep);
        chk({nm, ":stall_last"}, o_last, plast);
      end
      if (o_valid) begin
        if (in_gap) begin
          chk({nm, ":gap_len"}, gap_seen, gap);
          in_gap = 0;
        end
        if (r) begin
          chk({nm, ":beat_expected"}, expq.size() > 0, 1'b1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk({nm, ":data"}, o_data, e.data);
            chk({nm, ":keep"}, o_keep, e.keep);
            chk({nm, ":last"}, o_last, e.last);
            chk({nm, ":pkt_idx"}, o_pkt_idx, e.pkt);
            hs_n++;
            if (e.last) begin
              pk_done++;
              if (pk_done == eff) fin = 1;
              else begin in_gap = 1; gap_seen = 0; end
            end
          end else fin = 1;
        end
        prev_stall = !r; pdata = o_data; pkeep = o_keep; plast = o_last;
      end else begin
        prev_stall = 0;
        chk({nm, ":no_done_mid"}, o_done, 1'b0);
        if (in_gap) gap_seen++;
      end
      @(negedge clk);
    end
    i_abort = 1'b0; i_start = 1'b0;
    chk({nm, ":finished"}, fin, 1'b1);
    chk({nm, ":done"}, o_done, 1'b1);
    chk({nm, ":done_valid"}, o_valid, 1'b0);
    chk({nm, ":done_busy"}, o_busy, 1'b1);
    @(negedge clk);
    chk({nm, ":done_once"}, o_done, 1'b0);
    chk({nm, ":idle_busy"}, o_busy, 1'b0);
    chk({nm, ":idle_pkt_idx"}, o_pkt_idx, 0);
    @(negedge clk);
    chk({nm, ":idle_valid"}, o_valid, 1'b0);
    chk({nm, ":idle_done"}, o_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b1;
    i_length = '0; i_pkt_count = '0; i_gap = '0; i_mode = '0; i_seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_last", o_last, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_data", o_data, 0);
    chk("rst_keep", o_keep, 0);
    chk("rst_pkt_idx", o_pkt_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    run("incr256", 2'd0, 256, 1, 0, 32'h0, 0, -1);
    run("incr255", 2'd0, 255, 1, 0, 32'h0, 0, -1);
    run("stall", 2'd0, int'($urandom_range(100, 200)), 2, 1, $urandom, 1, -1);
    run("index", 2'd3, 64, 3, 4, 32'h0, 0, -1);
    run("abort", 2'd0, 64, 4, 2, 32'h10, 0, 2);
    run("prbs", 2'd1, int'($urandom_range(60, 120)), 2, int'($urandom_range(0, 3)), 32'h1, 2, -1);
    run("const", 2'd2, 37, 2, 0, $urandom, 2, -1);
    run("zero_len", 2'd0, 0, 3, 0, 32'h0, 0, -1);
    run("zero_cnt", 2'd0, 10, 0, 0, 32'h0, 0, -1);
    for (int t = 0; t < 6; t++)
      run("rand", 2'($urandom_range(0, 3)), int'($urandom_range(1, 80)),
          int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), $urandom, 2, -1);

    // reset in the middle of a packet
    i_ready = 1'b1; i_length = 16'd200; i_pkt_count = 8'd1; i_gap = 8'd0;
    i_mode = 2'd0; i_seed = 32'h0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_pre_valid", o_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_done", o_done, 1'b0);
    chk("midrst_data", o_data, 0);
    chk("midrst_keep", o_keep, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_done", o_done, 1'b0);
      chk("midrst_no_valid", o_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_stream_pattern_gen.md
# axi_stream_pattern_gen

Parametrised AXI4-Stream pattern source: on a start pulse it emits a run of one or more packets of byte-granular length, with selectable data pattern and programmable inter-packet gap, obeying full valid/ready back-pressure. It supersedes the fixed 64-bit single-packet generator as the stimulus source in front of the DMA/DDR datapaths and as the loop-back traffic source for link bring-up.

## Interface
- DATA_WIDTH, 64, stream width in bits; legal values are 32, 64, 128, 256 and 512. BYTES = DATA_WIDTH/8.
- LEN_WIDTH, 16, width of the byte-length field.
- CNT_WIDTH, 8, width of the packet-count field.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  run-start pulse; sampled only in IDLE.
- i_length  in  LEN_WIDTH  packet length in bytes.
- i_pkt_count  in  CNT_WIDTH  number of packets in the run.
- i_gap  in  8  idle cycles between packets.
- i_mode  in  2  data pattern: 0 = INCR, 1 = PRBS31, 2 = CONST, 3 = INDEX.
- i_seed  in  32  pattern seed.
- i_abort  in  1  stop the run at the next packet boundary.
- i_ready  in  1  AXIS tready.
- o_data  out  DATA_WIDTH  AXIS tdata.
- o_keep  out  BYTES  AXIS tkeep.
- o_valid  out  1  AXIS tvalid.
- o_last  out  1  AXIS tlast.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse at the end of a run.
- o_pkt_idx  out  CNT_WIDTH  index of the packet currently being sent.

## Operation
- FSM states are IDLE, SEND, GAP and DONE.
- IDLE -> SEND: on i_start. All i_* configuration is latched at this point. i_start is ignored outside IDLE.
- Zero-length run: if i_length = 0 or i_pkt_count = 0, the FSM goes IDLE -> DONE and emits no beats.
- Beat count per packet is ceil(i_length/BYTES).
- o_keep is all ones except on the last beat, where it equals (1 << (i_length mod BYTES)) - 1. If the remainder is 0, o_keep is all ones.
- On the last beat, bytes with keep = 0 are driven to zero in o_data.
- o_last is high on the last beat of every packet.
- A handshake occurs when o_valid & i_ready.
- After the last handshake of a packet:
  - If packets remain and no abort is pending: go to GAP when i_gap > 0, otherwise go directly to SEND.
  - If no packets remain or an abort is pending: go to DONE.
- DONE -> IDLE after one cycle. o_done = 1 in DONE only.
- i_abort is latched as pending while busy. The current packet always completes with o_last (AXIS-legal); remaining packets are dropped.
- Patterns, with k = beat index within the packet and p = packet index:
  - INCR: byte lane b = (i_seed[7:0] + k*BYTES + b) mod 256. Restarts at every packet.
  - PRBS31: bit j of beat n = s[n*DATA_WIDTH + j], where s[i] = s[i-31] ^ s[i-28] and s[0..30] = i_seed[30:0]. A seed of zero is replaced by 1. The sequence n continues across packets of the run.
  - CONST: i_seed replicated DATA_WIDTH/32 times.
  - INDEX: o_data = zero-extended {p[15:0], k[15:0]}.

## Timing
- Reset: state IDLE; o_valid, o_last, o_busy and o_done = 0; o_data, o_keep and o_pkt_idx = 0.
- A reset mid-run clears all outputs at the next edge. No o_done pulse is produced.
- Start latency: i_start sampled at edge e. o_valid and o_busy are high in the cycle after e, carrying the first beat.
- While o_valid & !i_ready, o_data, o_keep and o_last are held stable. o_valid never drops without a handshake.
- With i_ready held at 1, one beat is sent per cycle with no bubbles inside a packet, and no bubbles between packets when i_gap = 0.
- With i_gap = G > 0, o_valid is low for exactly G cycles between a packet's last handshake and the next packet's first beat.
- o_done is high in the cycle after the final last handshake.
- For a zero-length run, o_done is high in the cycle after the start cycle.
- o_busy is high from the first beat or DONE entry through the o_done cycle, and low the cycle after.
- o_pkt_idx increments on each o_last handshake and returns to 0 in IDLE.

## Test plan
- DATA_WIDTH=64, INCR, seed 0, length 256, count 1, i_ready always 1 -> 32 consecutive beats, keep 0xFF, first data 0x0706050403020100, o_last on beat 32, o_done one cycle later.
- Length 255, otherwise as above -> 32 beats; last beat has keep 0x7F and byte 7 = 0x00.
- i_ready toggled 1,0,1,0,0,1 repeatedly with INCR -> data stable while stalled; the byte sequence is contiguous with no drops or duplicates.
- INDEX mode, length 64, count 3, gap 4 -> 3 packets of 8 beats, exactly 4 idle cycles between packets; packet 1 beat 5 carries 0x0000000000010005; o_pkt_idx steps 0, 1, 2.
- Abort in beat 3 of packet 0 of a 4-packet run, plus i_start pulsed while busy -> packet 0 completes with o_last, no further o_valid, o_done pulses once, the second start is ignored.
- PRBS31 with seed 1 checked against a bench model across 2 packets. Length 0 -> no o_valid; o_done in the cycle after start. Reset mid-packet -> o_valid = 0 next cycle and no o_done.
